// File: rtl/mem_infer_seq_if.sv
// ============================================================================
//  Module      : mem_infer_seq_if
//  Description : ROM / cell-bank / result bundle for the inference sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_infer_seq_if #(
    parameter int N_FEAT  = 16,
    parameter int N_CLASS = 6,
    parameter int VW      = 16,
    parameter int IW      = 36,
    parameter int AW      = IW + $clog2(N_FEAT)
);
    logic                         start;
    logic                         clr_cells;
    logic [$clog2(N_FEAT)-1:0]    feat_addr;
    logic signed [VW-1:0]         feat_data;
    logic signed [VW-1:0]         cell_vin;
    logic                         cell_valid;
    logic                         cell_reset;
    logic [N_CLASS*IW-1:0]        cell_i;
    logic                         busy;
    logic                         done;
    logic [$clog2(N_CLASS)-1:0]   class_idx;
    logic signed [AW-1:0]         score;

    modport master (
        input  start, clr_cells, feat_data, cell_i,
        output feat_addr, cell_vin, cell_valid, cell_reset,
        output busy, done, class_idx, score
    );

    modport slave (
        output start, clr_cells, feat_data, cell_i,
        input  feat_addr, cell_vin, cell_valid, cell_reset,
        input  busy, done, class_idx, score
    );
endinterface

`default_nettype wire

// File: rtl/mem_infer_seq.sv
// ============================================================================
//  Module      : mem_infer_seq
//  Description : Streams a feature vector into the memristor cell bank,
//                accumulates per-class currents and reports the argmax class.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_infer_seq #(
    parameter int N_FEAT  = 16,
    parameter int N_CLASS = 6,
    parameter int VW      = 16,
    parameter int IW      = 36,
    parameter int AW      = IW + $clog2(N_FEAT)
) (
    input  logic            clk,
    input  logic            rst,
    mem_infer_seq_if.master bus
);

    localparam int c_kw = $clog2(N_FEAT);
    localparam int c_cw = $clog2(N_CLASS);
    localparam logic [c_kw-1:0] c_last_k = c_kw'(N_FEAT - 1);
    localparam logic [c_cw-1:0] c_last_j = c_cw'(N_CLASS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DRIVE   = 3'd2,
        S_CAPTURE = 3'd3,
        S_ARGMAX  = 3'd4,
        S_DONE    = 3'd5,
        S_CLR     = 3'd6
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [c_kw-1:0]        r_k;
    logic [c_cw-1:0]        r_j;
    logic signed [AW-1:0]   r_acc [N_CLASS];
    logic signed [AW-1:0]   w_ext [N_CLASS];
    logic [c_cw-1:0]        r_best_idx;
    logic signed [AW-1:0]   r_best_val;
    logic [c_cw-1:0]        r_class;
    logic signed [AW-1:0]   r_score;

    logic                   w_last_feat;
    logic                   w_last_class;
    logic signed [AW-1:0]   w_cand;
    logic                   w_take;
    logic [c_cw-1:0]        w_nxt_idx;
    logic signed [AW-1:0]   w_nxt_val;

    logic                   w_busy;
    logic                   w_done;
    logic                   w_valid;
    logic                   w_creset;
    logic signed [VW-1:0]   w_vin;

    genvar g;
    generate
        for (g = 0; g < N_CLASS; g++) begin : g_ext
            assign w_ext[g] = {{(AW-IW){bus.cell_i[g*IW + IW - 1]}}, bus.cell_i[g*IW +: IW]};
        end
    endgenerate

    assign w_last_feat  = (r_k == c_last_k);
    assign w_last_class = (r_j == c_last_j);

    // Slot 0 always wins so the running best needs no separate clear.
    assign w_cand    = r_acc[r_j];
    assign w_take    = (r_j == '0) || (w_cand > r_best_val);
    assign w_nxt_idx = w_take ? r_j    : r_best_idx;
    assign w_nxt_val = w_take ? w_cand : r_best_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_busy   = 1'b1;
        w_done   = 1'b0;
        w_valid  = 1'b0;
        w_creset = 1'b0;
        w_vin    = {VW{1'b0}};
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next = S_FETCH;
                end else if (bus.clr_cells) begin
                    w_next = S_CLR;
                end
            end
            S_CLR: begin
                w_valid  = 1'b1;
                w_creset = 1'b1;
                w_next   = S_IDLE;
            end
            S_FETCH: begin
                w_next = S_DRIVE;
            end
            S_DRIVE: begin
                w_valid = 1'b1;
                w_vin   = bus.feat_data;
                w_next  = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_next = w_last_feat ? S_ARGMAX : S_FETCH;
            end
            S_ARGMAX: begin
                if (w_last_class) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state == S_IDLE && bus.start)) begin
            for (int i = 0; i < N_CLASS; i++) begin
                r_acc[i] <= '0;
            end
        end else if (r_state == S_CAPTURE) begin
            for (int i = 0; i < N_CLASS; i++) begin
                r_acc[i] <= r_acc[i] + w_ext[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k        <= '0;
            r_j        <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
            r_class    <= '0;
            r_score    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_k <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (w_last_feat) begin
                        r_j <= '0;
                    end else begin
                        r_k <= r_k + c_kw'(1);
                    end
                end
                S_ARGMAX: begin
                    r_best_idx <= w_nxt_idx;
                    r_best_val <= w_nxt_val;
                    // Results land on the edge that enters DONE.
                    if (w_last_class) begin
                        r_class <= w_nxt_idx;
                        r_score <= w_nxt_val;
                    end else begin
                        r_j <= r_j + c_cw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.feat_addr  = r_k;
    assign bus.cell_vin   = w_vin;
    assign bus.cell_valid = w_valid;
    assign bus.cell_reset = w_creset;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.class_idx  = r_class;
    assign bus.score      = r_score;

endmodule

`default_nettype wire

// File: doc/mem_infer_seq.md
# mem_infer_seq

Inference sequencer for the memristor single-layer-perceptron array. Streams one quantized feature vector from a feature ROM into a bank of `N_CLASS` memristor cells, one feature per step. It accumulates the per-class cell currents over all features, then runs a sequential argmax to report the predicted activity class. It sits between the feature ROM and the cell bank and is the only driver of the bank's `Vin`/`V_valid`/`reset` pins.

## Interface
- `N_FEAT`, 16: features per inference vector (≥2).
- `N_CLASS`, 6: classes, equal to the number of cells in the bank (≥2).
- `VW`, 16: feature/`Vin` width, signed.
- `IW`, 36: per-cell current width, signed; matches the cell `I` output.
- `AW`, `IW+$clog2(N_FEAT)`: accumulator width, signed (derived).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin inference; sampled only in IDLE.
- `clr_cells` in 1: in IDLE, re-initialize all cells to `Ginit`. `start` has priority if both are high.
- `feat_addr` out `$clog2(N_FEAT)`: ROM address, registered.
- `feat_data` in VW: ROM data, valid the cycle after `feat_addr` changes.
- `cell_vin` out VW: bank `Vin`, broadcast to all cells.
- `cell_valid` out 1: bank `V_valid`.
- `cell_reset` out 1: bank `reset`.
- `cell_i` in `N_CLASS*IW`: packed cell currents, class j at `[j*IW +: IW]`. Registered in the cell on a `cell_valid` edge.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the result is valid.
- `class_idx` out `$clog2(N_CLASS)`: predicted class, held until the next `done`.
- `score` out AW: winning accumulator value, held until the next `done`.

## Operation
- States: IDLE, FETCH, DRIVE, CAPTURE, ARGMAX, DONE, CLR.
- IDLE:
  - On `start`: clear all `acc[j]`, set feature counter k=0 and `feat_addr`=0, go to FETCH.
  - Else on `clr_cells`: go to CLR.
- CLR (1 cycle): `cell_reset`=1 and `cell_valid`=1. Return to IDLE. `busy`=1.
- FETCH (1 cycle): `feat_addr`=k is stable; wait for ROM latency. Go to DRIVE.
- DRIVE (1 cycle): `cell_vin`=`feat_data`, `cell_valid`=1, `cell_reset`=0. The cells register I at the end of this cycle. Go to CAPTURE.
- CAPTURE (1 cycle): `acc[j] += sign-extended cell_i[j]` for every j.
  - If k==N_FEAT-1: j=0 and best index=0, go to ARGMAX.
  - Else: k++, `feat_addr`=k+1, go to FETCH.
- ARGMAX (`N_CLASS` cycles): cycle j compares `acc[j]` to the best so far.
  - Replace only if strictly greater; ties keep the lower index.
  - Cycle 0 loads `acc[0]` unconditionally.
  - After j==N_CLASS-1, go to DONE.
- DONE (1 cycle): register `class_idx` and `score`, pulse `done`, go to IDLE.
- Drive levels:
  - `cell_valid` is low in every state except DRIVE and CLR.
  - `cell_vin` is 0 outside DRIVE.
  - `cell_reset` is high only in CLR.
- Arithmetic: signed two's complement. AW has enough headroom that no overflow is possible; no saturation logic.
- `start`/`clr_cells` while `busy` are ignored, not queued.
- `rst` at any cycle:
  - State goes to IDLE next edge.
  - Accumulators, `feat_addr`, `class_idx`, `score` go to 0.
  - `busy`, `done`, `cell_valid`, `cell_reset` go to 0.
  - An in-flight inference is discarded; no `done`.

## Timing
- Reset values: every output is 0.
- Inference latency: with `start` sampled at edge E0, `done` is high during cycle `3*N_FEAT + N_CLASS + 1` after E0.
  - Default parameters: 55 cycles.
  - `busy` is high for `3*N_FEAT + N_CLASS + 1` cycles, including the DONE cycle.
- Feature cadence: one feature every 3 cycles. `cell_valid` is never high on two consecutive cycles during inference.
- `class_idx`/`score` update on the same edge that raises `done`, and stay stable afterwards.
- `start` may be asserted in the cycle right after `done`; there is no dead cycle.
- CLR occupies exactly 1 busy cycle.

## Test plan
- Basic inference (N_FEAT=4, N_CLASS=3, fixed cell model I=Vin×G, G={2,5,-1}, features {10,-3,7,1}):
  - acc={30,75,-15}.
  - Expect `class_idx`=1 and `score`=75, with `done` exactly 16 cycles after `start`.
- Tie: G={4,4,1} → `class_idx`=0 (lower index wins).
- All-negative: G={-3,-1,-7}, features all 5 → `class_idx`=1, `score`=-20.
- Reset mid-run: assert `rst` in cycle 7 of an inference.
  - Expect all outputs 0 next cycle, no `done`.
  - A fresh `start` gives the correct result.
- `clr_cells` and ignored inputs:
  - `clr_cells` in IDLE → one cycle with `cell_reset`=`cell_valid`=1, then IDLE.
  - `start`/`clr_cells` pulsed while `busy` → no effect, single `done`.
- Back-to-back: `start` in the cycle after `done` with a new feature vector.
  - Second result correct; accumulators were cleared between runs.
  - `cell_valid` pulse count is exactly 2×N_FEAT.
